// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iterative_alu
//  Purpose  : Multi-cycle ALU for the multi-cycle CPU datapath. Logic ops,
//             ADD and SUB finish in one cycle. Shifts move one bit position
//             per cycle, so no barrel shifter sits on the critical path.
//             Results come back through a start/busy/done handshake.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             start             - request, sampled only while idle
//             alu_op, btype     - operation and branch-type codes
//             alu_in_1/alu_in_2 - operands (alu_in_2 low bits = shamt)
//             busy, done        - handshake status (done is a 1-cycle pulse)
//             alu_result        - registered result
//             alu_bcond         - registered branch condition
//  Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            alu_op,
  input  logic [1:0]            btype,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond
);

  // Operation codes, mirroring alu_func.v.
  localparam logic [3:0] c_func_add = 4'b0000;
  localparam logic [3:0] c_func_sub = 4'b0001;
  localparam logic [3:0] c_func_and = 4'b0100;
  localparam logic [3:0] c_func_or  = 4'b0101;
  localparam logic [3:0] c_func_xor = 4'b1000;
  localparam logic [3:0] c_func_lls = 4'b1010;
  localparam logic [3:0] c_func_lrs = 4'b1011;
  localparam logic [3:0] c_func_ars = 4'b1100;

  // Branch types, mirroring opcodes.v.
  localparam logic [1:0] c_branch_eq = 2'b00;
  localparam logic [1:0] c_branch_ne = 2'b01;
  localparam logic [1:0] c_branch_lt = 2'b10;
  localparam logic [1:0] c_branch_ge = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic [3:0]              r_op;

  logic                    w_accept;
  logic                    w_is_shift;
  logic [SHAMT_WIDTH-1:0]  w_shamt;
  logic [DATA_WIDTH-1:0]   w_result;
  logic                    w_bcond;
  logic [DATA_WIDTH-1:0]   w_acc_shifted;
  logic                    w_last_shift;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_shamt      = alu_in_2[SHAMT_WIDTH-1:0];
  assign w_is_shift   = (alu_op == c_func_lls) || (alu_op == c_func_lrs) ||
                        (alu_op == c_func_ars);
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == SHAMT_WIDTH'(1));

  // Single-cycle result. A shift by zero simply passes operand A through,
  // which lets zero-amount shifts skip the SHIFT state entirely.
  always_comb begin
    w_result = '0;
    case (alu_op)
      c_func_add: w_result = alu_in_1 + alu_in_2;
      c_func_sub: w_result = alu_in_1 - alu_in_2;
      c_func_and: w_result = alu_in_1 & alu_in_2;
      c_func_or:  w_result = alu_in_1 | alu_in_2;
      c_func_xor: w_result = alu_in_1 ^ alu_in_2;
      c_func_lls,
      c_func_lrs,
      c_func_ars: w_result = alu_in_1;
      default:    w_result = '0;
    endcase
  end

  // Branch condition is only meaningful for the compare (SUB) operation.
  always_comb begin
    w_bcond = 1'b0;
    if (alu_op == c_func_sub) begin
      case (btype)
        c_branch_eq: w_bcond = (alu_in_1 == alu_in_2);
        c_branch_ne: w_bcond = (alu_in_1 != alu_in_2);
        c_branch_lt: w_bcond = ($signed(alu_in_1) <  $signed(alu_in_2));
        c_branch_ge: w_bcond = ($signed(alu_in_1) >= $signed(alu_in_2));
        default:     w_bcond = 1'b0;
      endcase
    end
  end

  // One-position step of the iterative shifter, using the latched opcode.
  always_comb begin
    w_acc_shifted = r_acc;
    case (r_op)
      c_func_lls: w_acc_shifted = {r_acc[DATA_WIDTH-2:0], 1'b0};
      c_func_lrs: w_acc_shifted = {1'b0, r_acc[DATA_WIDTH-1:1]};
      c_func_ars: w_acc_shifted = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
      default:    w_acc_shifted = r_acc;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_is_shift && (w_shamt != '0)) w_state_next = S_SHIFT;
          else                               w_state_next = S_DONE;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == SHAMT_WIDTH'(1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers. Operands are captured only on acceptance, so input
  // changes and ignored starts cannot disturb an operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      alu_result <= '0;
      alu_bcond  <= 1'b0;
    end else if (w_accept) begin
      r_op <= alu_op;
      if (w_is_shift && (w_shamt != '0)) begin
        // Result registers keep the previous value until the last shift.
        r_acc <= alu_in_1;
        r_cnt <= w_shamt;
      end else begin
        alu_result <= w_result;
        alu_bcond  <= w_bcond;
      end
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_shifted;
      r_cnt <= r_cnt - SHAMT_WIDTH'(1);
      if (w_last_shift) begin
        alu_result <= w_acc_shifted;
        alu_bcond  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iterative_alu
//  Purpose  : Directed self-checking bench for iterative_alu with
//             hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

  localparam logic [3:0] c_func_add = 4'b0000;
  localparam logic [3:0] c_func_sub = 4'b0001;
  localparam logic [3:0] c_func_and = 4'b0100;
  localparam logic [3:0] c_func_or  = 4'b0101;
  localparam logic [3:0] c_func_xor = 4'b1000;
  localparam logic [3:0] c_func_lls = 4'b1010;
  localparam logic [3:0] c_func_lrs = 4'b1011;
  localparam logic [3:0] c_func_ars = 4'b1100;

  localparam logic [1:0] c_branch_eq = 2'b00;
  localparam logic [1:0] c_branch_ne = 2'b01;
  localparam logic [1:0] c_branch_lt = 2'b10;
  localparam logic [1:0] c_branch_ge = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic [1:0]  btype;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        busy;
  logic        done;
  logic [31:0] alu_result;
  logic        alu_bcond;

  int n_checks = 0;
  int n_errors = 0;

  iterative_alu #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_op     (alu_op),
    .btype      (btype),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the
  // idle cycle following done. Latency counts cycles from the accepting edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] bt,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_bc);
    int  lat;
    int  busy_cnt;
    bit  seen;
    alu_op = op; btype = bt; alu_in_1 = a; alu_in_2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    // Scramble inputs to show they do not affect the operation in flight.
    alu_in_1 = ~a; alu_in_2 = ~b; alu_op = ~op;
    lat = 1; busy_cnt = 0; seen = 1'b0;
    while (lat <= 40 && !seen) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (seen) begin
      check({tag, " result"}, alu_result, exp_res);
      check({tag, " bcond"}, {31'b0, alu_bcond}, {31'b0, exp_bc});
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    end
    @(negedge clk);
    check({tag, " done pulse width"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin : main
    int          dones;
    int          done_cyc;
    logic [31:0] cap_res;

    reset = 1'b1; start = 1'b0; alu_op = '0; btype = '0;
    alu_in_1 = '0; alu_in_2 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {alu_result[29:0], alu_bcond, busy | done}, 32'd0);
    check("reset result", alu_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("add wrap",   c_func_add, c_branch_eq, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b0);
    run_op("sub lt",     c_func_sub, c_branch_lt, 32'hFFFF_FFFF, 32'h1, 1, 32'hFFFF_FFFE, 1'b1);
    run_op("sub ge",     c_func_sub, c_branch_ge, 32'hFFFF_FFFF, 32'h1, 1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub eq",     c_func_sub, c_branch_eq, 32'd5, 32'd5, 1, 32'h0, 1'b1);
    run_op("sub ne eq",  c_func_sub, c_branch_ne, 32'd5, 32'd5, 1, 32'h0, 1'b0);
    run_op("sub ne",     c_func_sub, c_branch_ne, 32'd5, 32'd6, 1, 32'hFFFF_FFFF, 1'b1);
    run_op("sub ge eq",  c_func_sub, c_branch_ge, 32'd5, 32'd5, 1, 32'h0, 1'b1);
    run_op("sub lt pos", c_func_sub, c_branch_lt, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("and",        c_func_and, c_branch_eq, 32'hF0F0_1234, 32'h0FF0_00FF, 1, 32'h00F0_0034, 1'b0);
    run_op("or",         c_func_or,  c_branch_eq, 32'hF0F0_1234, 32'h0FF0_00FF, 1, 32'hFFF0_12FF, 1'b0);
    run_op("xor",        c_func_xor, c_branch_eq, 32'hF0F0_1234, 32'h0FF0_00FF, 1, 32'hFF00_12CB, 1'b0);
    run_op("add no bc",  c_func_add, c_branch_lt, 32'd1, 32'd2, 1, 32'd3, 1'b0);
    run_op("undef op",   4'b1111,    c_branch_eq, 32'hDEAD_BEEF, 32'h1, 1, 32'h0, 1'b0);
    run_op("ars 31",     c_func_ars, c_branch_eq, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0);
    run_op("lrs 31",     c_func_lrs, c_branch_eq, 32'h8000_0000, 32'd31, 32, 32'h0000_0001, 1'b0);
    run_op("lls 4",      c_func_lls, c_branch_eq, 32'h1, 32'h24, 5, 32'h10, 1'b0);
    run_op("lls 0",      c_func_lls, c_branch_eq, 32'h1234, 32'h20, 1, 32'h1234, 1'b0);
    run_op("ars pos",    c_func_ars, c_branch_eq, 32'h4000_0000, 32'd2, 3, 32'h1000_0000, 1'b0);
    run_op("ars neg",    c_func_ars, c_branch_eq, 32'hF000_0000, 32'd4, 5, 32'hFF00_0000, 1'b0);
    run_op("sub bc clr", c_func_sub, c_branch_eq, 32'd7, 32'd7, 1, 32'h0, 1'b1);
    run_op("lrs bc clr", c_func_lrs, c_branch_eq, 32'h100, 32'd1, 2, 32'h80, 1'b0);

    // Start pulsed during a 10-cycle LRS must be ignored.
    alu_op = c_func_lrs; btype = c_branch_eq;
    alu_in_1 = 32'hF000_0000; alu_in_2 = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0; done_cyc = 0; cap_res = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) check("result held during shift", alu_result, 32'h80);
      if (c == 3) begin
        alu_op = c_func_add; alu_in_1 = 32'd1; alu_in_2 = 32'd2; start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_cyc = c;
          cap_res  = alu_result;
        end
      end
      if (dones == 0 || c < done_cyc + 1) @(negedge clk);
      else break;
    end
    check("ignored start done count", 32'(dones), 32'd1);
    check("ignored start latency", 32'(done_cyc), 32'd10);
    check("ignored start result", cap_res, 32'h0078_0000);
    // Now in the idle cycle right after done: a fresh start is accepted.
    run_op("b2b add", c_func_add, c_branch_eq, 32'd10, 32'd20, 1, 32'd30, 1'b0);

    // Reset during the third SHIFT cycle aborts the operation.
    alu_op = c_func_lls; alu_in_1 = 32'h1; alu_in_2 = 32'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("third shift cycle busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy/done", {30'b0, busy, done}, 32'd0);
    check("abort result", alu_result, 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort no done", 32'(dones), 32'd0);
    run_op("add after abort", c_func_add, c_branch_eq, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    // Reset together with start: reset wins.
    alu_op = c_func_add; alu_in_1 = 32'd4; alu_in_2 = 32'd4;
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("reset beats start", {alu_result[29:0], busy, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
